// File: rtl/frame_filter_scheduler.sv
// ---------------------------------------------------------------------------
// frame_filter_scheduler
//
// Purpose:
//   Routes a camera RGB565 write stream either straight into the frame buffer
//   (bypass) or through an external Sobel edge-filter engine, and can hold
//   ("freeze") the frame buffer. Path and freeze changes are taken only at a
//   frame start (a camera write to address 0). Leaving the filter path goes
//   through a drain phase so that the filter's in-flight pixels still land in
//   the frame buffer. The drain ends when the filter writes the last pixel of
//   the frame, or when a cycle budget runs out.
//
// Parameters:
//   IMG_WIDTH      pixels per line
//   IMG_HEIGHT     lines per frame
//   DRAIN_TIMEOUT  maximum number of cycles spent draining
//
// Optional feature (compile-time macro FRAME_CNT_EN):
//   When defined, adds the output frame_cnt, an 8-bit wrapping count of frame
//   buffer writes to the last pixel address. When undefined, the port and
//   its logic are absent.
//
// Ports:
//   clk                         sole clock, rising edge
//   reset                       synchronous, active-low (0 = reset)
//   we_in/wAddr_in/wData_in     camera write stream (in)
//   mode_req                    0 = bypass, 1 = edge filter (sampled at FS)
//   freeze_req                  1 = hold frame buffer (sampled at FS)
//   flt_we_in/_wAddr_in/_wData_in    stream to the filter engine (out)
//   flt_we_out/_wAddr_out/_wData_out stream from the filter engine (in)
//   fb_we/fb_wAddr/fb_wData     frame-buffer write port (out)
//   frame_cnt                   completed-frame counter (FRAME_CNT_EN only)
//   mode_active                 1 while the filter path is live
//   frozen                      1 while the frame buffer is held
//   busy                        1 while draining the filter
//
// All outputs are registered. Write ports carry address/data 0 whenever
// their write enable is 0.
// ---------------------------------------------------------------------------
module frame_filter_scheduler #(
  parameter int IMG_WIDTH     = 320,
  parameter int IMG_HEIGHT    = 240,
  parameter int DRAIN_TIMEOUT = 1280
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_in,
  input  logic [16:0] wAddr_in,
  input  logic [15:0] wData_in,
  input  logic        mode_req,
  input  logic        freeze_req,
  output logic        flt_we_in,
  output logic [16:0] flt_wAddr_in,
  output logic [15:0] flt_wData_in,
  input  logic        flt_we_out,
  input  logic [16:0] flt_wAddr_out,
  input  logic [15:0] flt_wData_out,
  output logic        fb_we,
  output logic [16:0] fb_wAddr,
  output logic [15:0] fb_wData,
`ifdef FRAME_CNT_EN
  output logic [7:0]  frame_cnt,
`endif
  output logic        mode_active,
  output logic        frozen,
  output logic        busy
);

  // Address of the final pixel of a frame.
  localparam logic [16:0] LAST = 17'(IMG_WIDTH * IMG_HEIGHT - 1);

  // The drain counter only has to reach DRAIN_TIMEOUT-1.
  localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_BYP   = 2'd0,
    ST_FLT   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FROZ  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             target_froz_reg, target_froz_next;
  logic [CNT_W-1:0] drain_cnt_reg, drain_cnt_next;

  logic             fb_we_reg, fb_we_next;
  logic [16:0]      fb_addr_reg, fb_addr_next;
  logic [15:0]      fb_data_reg, fb_data_next;
  logic             flt_we_reg, flt_we_next;
  logic [16:0]      flt_addr_reg, flt_addr_next;
  logic [15:0]      flt_data_reg, flt_data_next;
  logic             mode_active_reg, frozen_reg, busy_reg;

  // Routing decisions for the current cycle.
  logic             cam_to_fb;
  logic             cam_to_flt;
  logic             filt_to_fb;

  logic             fs;
  logic             last_seen;

  assign fs        = we_in && (wAddr_in == 17'd0);
  assign last_seen = flt_we_out && (flt_wAddr_out == LAST);

  // -------------------------------------------------------------------------
  // Next-state and routing
  // -------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    target_froz_next = target_froz_reg;
    drain_cnt_next   = '0;
    cam_to_fb        = 1'b0;
    cam_to_flt       = 1'b0;
    filt_to_fb       = 1'b0;
    fb_we_next       = 1'b0;
    fb_addr_next     = '0;
    fb_data_next     = '0;
    flt_we_next      = 1'b0;
    flt_addr_next    = '0;
    flt_data_next    = '0;

    case (state_reg)
      ST_BYP: begin
        // Freeze outranks a path change; the FS pixel is dropped on freeze
        // and handed to the filter on a switch to the filter path.
        if (fs && freeze_req) begin
          state_next = ST_FROZ;
        end else if (fs && mode_req) begin
          state_next = ST_FLT;
          cam_to_flt = 1'b1;
        end else begin
          cam_to_fb = 1'b1;
        end
      end

      ST_FLT: begin
        filt_to_fb = 1'b1;
        if (fs && (freeze_req || !mode_req)) begin
          // Remember where to go once the filter has drained; the FS pixel
          // belongs to the new frame and is not sent into the filter.
          state_next       = ST_DRAIN;
          target_froz_next = freeze_req;
        end else begin
          cam_to_flt = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Camera traffic is discarded; the filter keeps writing the buffer,
        // including the last-pixel write that ends the drain.
        filt_to_fb = 1'b1;
        if (last_seen || (drain_cnt_reg == CNT_LAST)) begin
          state_next = target_froz_reg ? ST_FROZ : ST_BYP;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end

      ST_FROZ: begin
        if (fs && !freeze_req) begin
          if (mode_req) begin
            state_next = ST_FLT;
            cam_to_flt = 1'b1;
          end else begin
            state_next = ST_BYP;
            cam_to_fb  = 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_BYP;
      end
    endcase

    // Camera and filter sources never target the frame buffer together.
    if (cam_to_fb && we_in) begin
      fb_we_next   = 1'b1;
      fb_addr_next = wAddr_in;
      fb_data_next = wData_in;
    end else if (filt_to_fb && flt_we_out) begin
      fb_we_next   = 1'b1;
      fb_addr_next = flt_wAddr_out;
      fb_data_next = flt_wData_out;
    end

    if (cam_to_flt && we_in) begin
      flt_we_next   = 1'b1;
      flt_addr_next = wAddr_in;
      flt_data_next = wData_in;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_BYP;
      target_froz_reg <= 1'b0;
      drain_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      target_froz_reg <= target_froz_next;
      drain_cnt_reg   <= drain_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers. Status flags follow the state register, so they move
  // one cycle after the state itself changes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      fb_we_reg       <= 1'b0;
      fb_addr_reg     <= '0;
      fb_data_reg     <= '0;
      flt_we_reg      <= 1'b0;
      flt_addr_reg    <= '0;
      flt_data_reg    <= '0;
      mode_active_reg <= 1'b0;
      frozen_reg      <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      fb_we_reg       <= fb_we_next;
      fb_addr_reg     <= fb_addr_next;
      fb_data_reg     <= fb_data_next;
      flt_we_reg      <= flt_we_next;
      flt_addr_reg    <= flt_addr_next;
      flt_data_reg    <= flt_data_next;
      mode_active_reg <= (state_reg == ST_FLT);
      frozen_reg      <= (state_reg == ST_FROZ);
      busy_reg        <= (state_reg == ST_DRAIN);
    end
  end

`ifdef FRAME_CNT_EN
  // Counts frames as they complete in the frame buffer, i.e. on the
  // registered write of the last pixel address.
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_reg <= 8'd0;
    end else if (fb_we_reg && (fb_addr_reg == LAST)) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign fb_we        = fb_we_reg;
  assign fb_wAddr     = fb_addr_reg;
  assign fb_wData     = fb_data_reg;
  assign flt_we_in    = flt_we_reg;
  assign flt_wAddr_in = flt_addr_reg;
  assign flt_wData_in = flt_data_reg;
  assign mode_active  = mode_active_reg;
  assign frozen       = frozen_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_frame_filter_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_filter_scheduler
//
// Drives frame_filter_scheduler (8x8 image, drain budget 16) with random
// pixel data, random idle gaps, random filter-engine traffic and random
// mode/freeze toggling between frame starts. Expected outputs come from a
// reference model that tracks which path is live and where each cycle's
// camera and filter writes must end up.
// ---------------------------------------------------------------------------
module tb_frame_filter_scheduler;

  localparam int          W    = 8;
  localparam int          H    = 8;
  localparam int          DT   = 16;
  localparam logic [16:0] LAST = 17'(W * H - 1);

  logic        clk;
  logic        reset;
  logic        we_in;
  logic [16:0] wAddr_in;
  logic [15:0] wData_in;
  logic        mode_req;
  logic        freeze_req;
  logic        flt_we_in;
  logic [16:0] flt_wAddr_in;
  logic [15:0] flt_wData_in;
  logic        flt_we_out;
  logic [16:0] flt_wAddr_out;
  logic [15:0] flt_wData_out;
  logic        fb_we;
  logic [16:0] fb_wAddr;
  logic [15:0] fb_wData;
  logic        mode_active;
  logic        frozen;
  logic        busy;
`ifdef FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  frame_filter_scheduler #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .we_in        (we_in),
    .wAddr_in     (wAddr_in),
    .wData_in     (wData_in),
    .mode_req     (mode_req),
    .freeze_req   (freeze_req),
    .flt_we_in    (flt_we_in),
    .flt_wAddr_in (flt_wAddr_in),
    .flt_wData_in (flt_wData_in),
    .flt_we_out   (flt_we_out),
    .flt_wAddr_out(flt_wAddr_out),
    .flt_wData_out(flt_wData_out),
    .fb_we        (fb_we),
    .fb_wAddr     (fb_wAddr),
    .fb_wData     (fb_wData),
`ifdef FRAME_CNT_EN
    .frame_cnt    (frame_cnt),
`endif
    .mode_active  (mode_active),
    .frozen       (frozen),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef enum int {M_BYP, M_FLT, M_DRAIN, M_FROZ} mstate_t;

  mstate_t     m_path;
  bit          m_to_froz;
  int          m_drain_first;   // first cycle index spent draining
  int          cyc;
  logic [33:0] exp_fb;          // {we, addr, data}
  logic [33:0] exp_flt;
  logic [2:0]  exp_stat;        // {mode_active, frozen, busy}
  logic [7:0]  exp_cnt;

  int n_vec;
  int n_bad;
  int busy_run;
  int fbw_run;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Predict the outputs that appear after the coming clock edge.
  task automatic model_step();
    bit          fs;
    logic [33:0] cam;
    logic [33:0] fil;
    fs  = (we_in === 1'b1) && (wAddr_in == 17'd0);
    cam = we_in ? {1'b1, wAddr_in, wData_in} : 34'd0;
    fil = flt_we_out ? {1'b1, flt_wAddr_out, flt_wData_out} : 34'd0;

    if (exp_fb[33] && (exp_fb[32:16] == LAST)) exp_cnt = exp_cnt + 8'd1;
    exp_stat = {m_path == M_FLT, m_path == M_FROZ, m_path == M_DRAIN};
    exp_fb   = 34'd0;
    exp_flt  = 34'd0;

    if (reset === 1'b0) begin
      m_path    = M_BYP;
      m_to_froz = 1'b0;
      exp_stat  = 3'b000;
      exp_cnt   = 8'd0;
      return;
    end

    case (m_path)
      M_BYP: begin
        if (fs && freeze_req) m_path = M_FROZ;
        else if (fs && mode_req) begin
          m_path  = M_FLT;
          exp_flt = cam;
        end else exp_fb = cam;
      end
      M_FLT: begin
        exp_fb = fil;
        if (fs && (freeze_req || !mode_req)) begin
          m_path        = M_DRAIN;
          m_to_froz     = freeze_req;
          m_drain_first = cyc + 1;
        end else exp_flt = cam;
      end
      M_DRAIN: begin
        exp_fb = fil;
        if ((flt_we_out && flt_wAddr_out == LAST) || (cyc - m_drain_first == DT - 1))
          m_path = m_to_froz ? M_FROZ : M_BYP;
      end
      default: begin
        if (fs && !freeze_req) begin
          if (mode_req) begin
            m_path  = M_FLT;
            exp_flt = cam;
          end else begin
            m_path = M_BYP;
            exp_fb = cam;
          end
        end
      end
    endcase
  endtask

  // One clock: predict, advance, then compare on the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("fb_port",  {fb_we, fb_wAddr, fb_wData}, exp_fb);
    chk("flt_port", {flt_we_in, flt_wAddr_in, flt_wData_in}, exp_flt);
    chk("status",   34'({mode_active, frozen, busy}), 34'(exp_stat));
`ifdef FRAME_CNT_EN
    chk("frame_cnt", 34'(frame_cnt), 34'(exp_cnt));
`endif
    if (busy === 1'b1) busy_run++;
    if (fb_we === 1'b1) fbw_run++;
    $display("cyc=%0d we=%0b a=%0d fb=%0b/%0d flt=%0b/%0d st=%03b",
             cyc, we_in, wAddr_in, fb_we, fb_wAddr, flt_we_in, flt_wAddr_in,
             {mode_active, frozen, busy});
  endtask

  task automatic cam_idle();
    we_in    = 1'b0;
    wAddr_in = 17'($urandom);
    wData_in = 16'($urandom);
  endtask

  task automatic filt_idle();
    flt_we_out    = 1'b0;
    flt_wAddr_out = 17'($urandom);
    flt_wData_out = 16'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cam_idle();
      filt_idle();
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    idle(n);
    reset = 1'b1;
  endtask

  // Stream one frame 0..LAST. m/f are the requests presented at FS;
  // emit_at is the step at which the filter writes LAST (-1 = never);
  // gap_pct is the idle-cycle probability; jitter toggles the requests
  // between frame starts; stop_at aborts the frame early (-1 = never).
  task automatic run_frame(input bit m, input bit f, input int emit_at,
                           input int gap_pct, input bit jitter, input int stop_at);
    int px;
    int step;
    px   = 0;
    step = 0;
    while (px < W * H) begin
      if (step == stop_at) break;
      if (px == 0 || $urandom_range(99) >= gap_pct) begin
        we_in    = 1'b1;
        wAddr_in = 17'(px);
        wData_in = 16'($urandom);
        px++;
      end else cam_idle();
      if (step == 0 || !jitter) begin
        mode_req   = m;
        freeze_req = f;
      end else begin
        mode_req   = 1'($urandom);
        freeze_req = 1'($urandom);
      end
      if (step == emit_at) begin
        flt_we_out    = 1'b1;
        flt_wAddr_out = LAST;
        flt_wData_out = 16'($urandom);
      end else if ($urandom_range(1) == 1) begin
        flt_we_out    = 1'b1;
        flt_wAddr_out = 17'($urandom_range(0, W * H - 2));
        flt_wData_out = 16'($urandom);
      end else filt_idle();
      tick();
      step++;
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; busy_run = 0; fbw_run = 0;
    m_path = M_BYP; m_to_froz = 1'b0; m_drain_first = 0;
    exp_fb = '0; exp_flt = '0; exp_stat = '0; exp_cnt = '0;
    mode_req = 1'b0; freeze_req = 1'b0;
    cam_idle();
    filt_idle();

    // Reset state, then a plain bypass frame and a gappy one.
    do_reset(3);
    idle(2);
    run_frame(1'b0, 1'b0, -1, 0, 1'b0, -1);
    run_frame(1'b0, 1'b0, -1, 30, 1'b1, -1);

    // Filter path for two frames.
    run_frame(1'b1, 1'b0, -1, 20, 1'b1, -1);
    run_frame(1'b1, 1'b0, -1, 20, 1'b1, -1);

    // Back to bypass; filter finishes 5 cycles after FS.
    busy_run = 0;
    run_frame(1'b0, 1'b0, 5, 0, 1'b1, -1);
    chk("drain_last_len", 34'(busy_run), 34'(5));
    run_frame(1'b0, 1'b0, -1, 20, 1'b1, -1);

    // Freeze with the filter never finishing: full timeout drain.
    run_frame(1'b1, 1'b0, -1, 10, 1'b1, -1);
    busy_run = 0;
    run_frame(1'b0, 1'b1, -1, 0, 1'b1, -1);
    chk("drain_timeout_len", 34'(busy_run), 34'(DT));
    fbw_run = 0;
    run_frame(1'b0, 1'b1, -1, 20, 1'b1, -1);
    run_frame(1'b1, 1'b1, -1, 20, 1'b1, -1);
    chk("frozen_fb_writes", 34'(fbw_run), 34'(0));
    run_frame(1'b1, 1'b0, -1, 10, 1'b1, -1);

    // Both drain exits on the same cycle, towards bypass then freeze.
    busy_run = 0;
    run_frame(1'b0, 1'b0, DT, 0, 1'b1, -1);
    chk("drain_coincide_byp", 34'(busy_run), 34'(DT));
    run_frame(1'b1, 1'b0, -1, 10, 1'b1, -1);
    busy_run = 0;
    run_frame(1'b0, 1'b1, DT, 0, 1'b1, -1);
    chk("drain_coincide_froz", 34'(busy_run), 34'(DT));
    run_frame(1'b0, 1'b0, -1, 10, 1'b1, -1);

    // Reset in the middle of a drain.
    run_frame(1'b1, 1'b0, -1, 0, 1'b1, -1);
    run_frame(1'b0, 1'b0, -1, 0, 1'b1, 6);
    do_reset(1);
    chk("reset_mid_drain", {fb_we, flt_we_in, mode_active, frozen, busy}, 34'd0);
    run_frame(1'b0, 1'b0, -1, 0, 1'b0, -1);

    // Randomized frames.
    for (int i = 0; i < 24; i++) begin
      run_frame(1'($urandom), 1'($urandom_range(3) == 0),
                ($urandom_range(1) == 1) ? int'($urandom_range(1, 40)) : -1,
                int'($urandom_range(0, 40)), 1'b1, -1);
    end
    idle(3);

`ifdef FRAME_CNT_EN
    // 257 bypass frames wrap the counter once and land on 1.
    do_reset(2);
    for (int i = 0; i < 257; i++) run_frame(1'b0, 1'b0, -1, 0, 1'b0, -1);
    idle(1);
    chk("frame_cnt_257", 34'(frame_cnt), 34'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
